// File: rtl/hamming_encoder_74_tx.sv
// hamming_encoder_74_tx
// Hamming(7,4) encoder with a one-wire serial transmitter. It takes a nibble
// over a valid/ready handshake and sends the codeword on tx_bit, position 1
// first. Each code bit is held for BIT_CYCLES enabled cycles.
// Optional build macro HAMMING_TX_PARITY_EN appends an overall even-parity
// bit p0 after position 7, which gives extended Hamming(8,4) frames.
module hamming_encoder_74_tx #(
  parameter int   BIT_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic [2:0] bit_idx,
  output logic [6:0] codeword_out,
  output logic       frame_done
);

  typedef enum logic {IDLE, SEND} state_t;

  // Terminal value of the per-bit hold counter (stays 0 when BIT_CYCLES=1).
  localparam logic [3:0] CNT_LAST = 4'(BIT_CYCLES - 1);

`ifdef HAMMING_TX_PARITY_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  state_t     state;
  logic [3:0] cnt;
  logic       done_q;
  logic [6:0] enc;
  logic [7:0] frame_vec;
  logic [2:0] next_idx;
  logic       accept;

  // Even parity; bit[k] of the result is codeword position k+1.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  assign enc = encode(data_in);

  // The transmitted frame is indexed by bit_idx. The top slot holds p0 only
  // when the parity option is built in, and is never reached otherwise.
`ifdef HAMMING_TX_PARITY_EN
  assign frame_vec = {^codeword_out, codeword_out};
`else
  assign frame_vec = {1'b0, codeword_out};
`endif

  assign next_idx   = bit_idx + 3'd1;
  assign data_ready = (state == IDLE) & ena & ~rst;
  assign accept     = data_valid & data_ready;

  // The done pulse is masked while the block is frozen. A pulse interrupted
  // by ena=0 is therefore shown once, when ena returns.
  assign frame_done = done_q & ena;

  // Handshake, bit sequencing and hold counter; everything freezes when ena=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tx_bit       <= IDLE_LEVEL;
      tx_valid     <= 1'b0;
      bit_idx      <= 3'd0;
      codeword_out <= 7'd0;
      done_q       <= 1'b0;
      cnt          <= 4'd0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= SEND;
            codeword_out <= enc;
            tx_bit       <= enc[0];
            tx_valid     <= 1'b1;
            bit_idx      <= 3'd0;
            cnt          <= 4'd0;
          end
        end
        SEND: begin
          if (cnt == CNT_LAST) begin
            cnt <= 4'd0;
            if (bit_idx == LAST_IDX) begin
              state    <= IDLE;
              tx_bit   <= IDLE_LEVEL;
              tx_valid <= 1'b0;
              bit_idx  <= 3'd0;
              done_q   <= 1'b1;
            end else begin
              bit_idx <= next_idx;
              tx_bit  <= frame_vec[next_idx];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_encoder_74_tx.sv
// Self-checking bench for hamming_encoder_74_tx. Two instances share the
// stimulus: u1 (BIT_CYCLES=1, IDLE_LEVEL=0) and u3 (BIT_CYCLES=3,
// IDLE_LEVEL=1). The variable sel picks which one is observed.
module tb_hamming_encoder_74_tx;

`ifdef HAMMING_TX_PARITY_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif

  logic       clk = 1'b0;
  logic       rst, ena, data_valid;
  logic [3:0] data_in;

  logic       rdy1, tx1, txv1, fd1, rdy3, tx3, txv3, fd3;
  logic [2:0] idx1, idx3;
  logic [6:0] cw1, cw3;

  hamming_encoder_74_tx #(.BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy1), .tx_bit(tx1), .tx_valid(txv1), .bit_idx(idx1),
    .codeword_out(cw1), .frame_done(fd1));

  hamming_encoder_74_tx #(.BIT_CYCLES(3), .IDLE_LEVEL(1'b1)) u3 (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy3), .tx_bit(tx3), .tx_valid(txv3), .bit_idx(idx3),
    .codeword_out(cw3), .frame_done(fd3));

  always #5 clk = ~clk;

  logic       sel;
  logic       s_rdy, s_tx, s_txv, s_fd, s_idle;
  logic [2:0] s_idx;
  logic [6:0] s_cw;
  int         s_bc;
  assign s_rdy  = sel ? rdy3 : rdy1;
  assign s_tx   = sel ? tx3  : tx1;
  assign s_txv  = sel ? txv3 : txv1;
  assign s_fd   = sel ? fd3  : fd1;
  assign s_idx  = sel ? idx3 : idx1;
  assign s_cw   = sel ? cw3  : cw1;
  assign s_idle = sel;
  assign s_bc   = sel ? 3 : 1;

  int checks = 0;
  int errors = 0;

  // Reference frame from the classic Hamming construction. Data bits sit at
  // the non-power-of-two positions 3,5,6,7. Parity bit 2^k covers every
  // position with bit k set. Bit[7] is the overall parity of positions 1..7.
  function automatic logic [7:0] ref_frame(input logic [3:0] d);
    logic [7:1] pos;
    int dpos [4];
    logic par;
    dpos = '{3, 5, 6, 7};
    pos = '0;
    for (int k = 0; k < 4; k++) pos[dpos[k]] = d[k];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int q = 3; q <= 7; q++) if ((q & p) != 0) par = par ^ pos[q];
      pos[p] = par;
    end
    return {^pos, pos};
  endfunction

  // Present a nibble and wait (bounded) until the observed DUT takes it.
  // Returns one cycle after the accepting edge.
  task automatic do_accept(input logic [3:0] nib, input bit hold);
    int n = 0;
    data_in = nib; data_valid = 1'b1; ena = 1'b1;
    #1;
    while (!s_rdy && n < 60) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: data_ready=%b after %0d cycles, required 1", s_rdy, n);
    end
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  // Walk one frame starting in the first SEND cycle. ena can be dropped at
  // a fixed bit index or at random. data_in/data_valid can be scrambled
  // during SEND. The task ends in the frame_done cycle after checking it.
  task automatic check_frame(input logic [7:0] exp, input int stall_idx, input int stall_len,
                             input bit rand_stall, input bit scribble, input string nm);
    int i = 0, c = 0, stalled = 0;
    logic e;
    while (i < NB) begin
      if (i == stall_idx && c == 0 && stalled < stall_len) begin
        e = 1'b0; stalled++;
      end else if (rand_stall && $urandom_range(3) == 0) e = 1'b0;
      else e = 1'b1;
      ena = e;
      if (scribble) begin data_in = 4'($urandom); data_valid = 1'($urandom); end
      #1;
      checks++;
      if (s_txv !== 1'b1 || s_tx !== exp[i] || s_idx !== 3'(i) || s_rdy !== 1'b0 ||
          s_fd !== 1'b0 || s_cw !== exp[6:0]) begin
        errors++;
        $display("FAIL %s bit %0d sub %0d: txv=%b tx=%b idx=%0d rdy=%b fd=%b cw=%b, required 1 %b %0d 0 0 %b",
                 nm, i, c, s_txv, s_tx, s_idx, s_rdy, s_fd, s_cw, exp[i], i, exp[6:0]);
      end
      @(negedge clk);
      if (e) begin
        c++;
        if (c == s_bc) begin c = 0; i++; end
      end
    end
    ena = 1'b1;
    if (scribble) data_valid = 1'b0;
    #1;
    checks++;
    if (s_fd !== 1'b1 || s_txv !== 1'b0 || s_tx !== s_idle || s_idx !== 3'd0 ||
        s_rdy !== 1'b1 || s_cw !== exp[6:0]) begin
      errors++;
      $display("FAIL %s done: fd=%b txv=%b tx=%b idx=%0d rdy=%b cw=%b, required 1 0 %b 0 1 %b",
               nm, s_fd, s_txv, s_tx, s_idx, s_rdy, s_cw, s_idle, exp[6:0]);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; ena = 1'b1; data_valid = 1'b0; data_in = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; data_valid = 1'b0; data_in = 4'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      checks++;
      if (s_rdy !== 1'b0) begin
        errors++; $display("FAIL reset_ready: data_ready=%b during rst, required 0", s_rdy);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sel = 1'(s); #1;
        checks++;
        if (s_txv !== 1'b0 || s_tx !== s_idle || s_rdy !== 1'b1 || s_fd !== 1'b0 ||
            s_idx !== 3'd0 || s_cw !== 7'd0) begin
          errors++;
          $display("FAIL reset_idle sel%0d cyc%0d: txv=%b tx=%b rdy=%b fd=%b idx=%0d cw=%b, required 0 %b 1 0 0 0",
                   s, k, s_txv, s_tx, s_rdy, s_fd, s_idx, s_cw, s_idle);
        end
      end
    end
  endtask

  task automatic test_basic_bc1();
    apply_reset(); sel = 1'b0;
    checks++;
    if (ref_frame(4'b1011) !== {1'b0, 7'b1010101}) begin
      errors++; $display("FAIL model_1011: ref=%b, required 01010101", ref_frame(4'b1011));
    end
    do_accept(4'b1011, 1'b0);
    check_frame(ref_frame(4'b1011), -1, 0, 1'b0, 1'b1, "bc1_1011");
  endtask

  task automatic test_bc3();
    apply_reset(); sel = 1'b1;
    do_accept(4'b0001, 1'b0);
    check_frame(ref_frame(4'b0001), -1, 0, 1'b0, 1'b1, "bc3_0001");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      apply_reset(); sel = 1'(s);
      do_accept(4'b1111, 1'b1);
      data_in = 4'b0000;
      check_frame(ref_frame(4'b1111), -1, 0, 1'b0, 1'b0, "b2b_first");
      @(negedge clk);
      data_valid = 1'b0;
      check_frame(ref_frame(4'b0000), -1, 0, 1'b0, 1'b0, "b2b_second");
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(); sel = 1'b0;
    do_accept(4'b1011, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (s_idx !== 3'd3 || s_txv !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: idx=%0d txv=%b, required 3 1", s_idx, s_txv);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (s_txv !== 1'b0 || s_tx !== s_idle || s_idx !== 3'd0 || s_cw !== 7'd0 ||
        s_rdy !== 1'b0 || s_fd !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: txv=%b tx=%b idx=%0d cw=%b rdy=%b fd=%b, required 0 %b 0 0 0 0",
               s_txv, s_tx, s_idx, s_cw, s_rdy, s_fd, s_idle);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      checks++;
      if (s_fd !== 1'b0 || s_txv !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet cyc%0d: fd=%b txv=%b, required 0 0", k, s_fd, s_txv);
      end
    end
  endtask

  task automatic test_ena_stall();
    apply_reset(); sel = 1'b0;
    do_accept(4'b1011, 1'b0);
    check_frame(ref_frame(4'b1011), 2, 4, 1'b0, 1'b0, "stall_1011");
  endtask

  task automatic test_random();
    logic [3:0] nib;
    apply_reset();
    for (int f = 0; f < 30; f++) begin
      sel = 1'($urandom);
      nib = 4'($urandom);
      do_accept(nib, 1'b0);
      check_frame(ref_frame(nib), -1, 0, 1'b1, 1'b1, "random");
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_bc1();
    test_bc3();
    test_back_to_back();
    test_mid_reset();
    test_ena_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_encoder_74_tx.md
Name: hamming_encoder_74_tx

Overview:
Hamming(7,4) encoder plus serial transmitter. It is the sending end of the single-bit serial link consumed by the existing Hamming(7,4) decoder.
- Accepts a 4-bit nibble over a valid/ready handshake.
- Computes the three parity bits.
- Shifts the 7-bit codeword out on one wire, position 1 first.
- Sits between user logic (ui_in) and a dedicated output pin that loops to the decoder's serial input.

Parameters:
BIT_CYCLES, 1, clock cycles each code bit is held on tx_bit (legal range 1..16)
IDLE_LEVEL, 0, value driven on tx_bit when no frame is active

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
ena  input  1  global enable; low freezes all state
data_in  input  4  nibble to encode; d1=data_in[0], d2=[1], d3=[2], d4=[3]
data_valid  input  1  data_in is valid this cycle
data_ready  output  1  block can accept a nibble this cycle
tx_bit  output  1  serial code bit
tx_valid  output  1  high while tx_bit carries a code bit
bit_idx  output  3  index (0-based) of the bit currently on tx_bit; debug
codeword_out  output  7  latched codeword, bit[k] = position k+1; debug
frame_done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Single clock domain; all registers update on the rising edge of clk.
- rst=1 at a clock edge, from any state including mid-frame (frame is dropped):
  - state=IDLE, tx_bit=IDLE_LEVEL, tx_valid=0, bit_idx=0, codeword_out=0, frame_done=0, cycle counter=0.
  - data_ready=0 while rst=1; data_ready=1 from the first cycle after release.
- ena=0: every register holds its value, data_ready=0, frame_done does not pulse. Resuming continues exactly where the frame stopped.
- Parity, even:
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
  - Codeword positions 1..7 = p1 p2 d1 p3 d2 d3 d4.
- States: IDLE and SEND.
- IDLE:
  - data_ready=1 (when ena=1), tx_valid=0, tx_bit=IDLE_LEVEL.
  - Accept = data_valid & data_ready & ena. On accept, codeword_out is latched and the next state is SEND with bit_idx=0.
- SEND:
  - data_ready=0; data_valid is ignored.
  - tx_valid=1; tx_bit = codeword bit bit_idx (position bit_idx+1).
  - Each bit is held for exactly BIT_CYCLES enabled cycles, then bit_idx increments.
  - After the final cycle of the last bit (bit_idx=6, or 7 with the option on), the next state is IDLE with frame_done=1 for one cycle and bit_idx=0.
- Latency: the first code bit appears on tx_bit the cycle after accept. Frame length is 7*BIT_CYCLES cycles.
- Back-to-back frames: data_ready is high in the frame_done cycle, so a new nibble is accepted there. This gives a minimum inter-frame gap of one IDLE cycle.
- codeword_out holds its value until the next accept or reset.
- data_in changing during SEND has no effect.
- BIT_CYCLES=1: the bit changes every cycle; the cycle counter is unused but must still synthesize.

Optional Feature:
Macro HAMMING_TX_PARITY_EN.
- Defined:
  - An 8th bit, p0 = XOR of all 7 codeword bits (overall even parity, extended Hamming(8,4)), is sent after position 7 at bit_idx=7.
  - The frame is 8*BIT_CYCLES cycles and frame_done follows bit_idx=7.
  - codeword_out stays 7 bits; p0 is not exposed on it.
- Undefined: 7-bit frames only; no p0 logic is present.

Test Plan:
- Reset, then idle with data_valid=0 for 5 cycles -> tx_valid=0, tx_bit=IDLE_LEVEL, data_ready=1, frame_done never pulses.
- BIT_CYCLES=1, data_in=4'b1011 accepted -> codeword_out=7'b1010101.
  - tx_bit sequence is 1,0,1,0,1,0,1 over bit_idx 0..6.
  - frame_done pulses in cycle 8 after accept.
  - With HAMMING_TX_PARITY_EN: an extra bit 0, and frame_done pulses in cycle 9.
- BIT_CYCLES=3, data_in=4'b0001 -> tx_bit is 1,1,1,0,0,0,0, each bit held 3 cycles (21 cycles).
  - With the option: 22nd–24th cycles carry p0=1.
- data_in=4'b1111, then 4'b0000 presented with data_valid held high:
  - First frame is all ones.
  - The second is accepted in the frame_done cycle; its first bit 0 appears one cycle later.
  - data_ready=0 throughout SEND.
- Mid-frame rst=1 at bit_idx=3 -> the next cycle shows tx_valid=0, tx_bit=IDLE_LEVEL, bit_idx=0, codeword_out=0, data_ready=0. No frame_done pulse.
- ena=0 for 4 cycles at bit_idx=2 of 4'b1011 -> tx_bit, bit_idx and counter frozen. The frame resumes and completes with the correct 7 bits and total length 7+4 cycles.
